// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the bcd_counter_scan block.
//   BCD_W     : width of one BCD digit
//   BCD_MAX   : largest legal digit value (9)
//   BCD_ZERO  : digit value zero
//   bcd_clamp : limits a raw nibble to the legal BCD range 0..9
package bcd_pkg;

    localparam int                BCD_W    = 4;
    localparam logic [BCD_W-1:0]  BCD_MAX  = 4'd9;
    localparam logic [BCD_W-1:0]  BCD_ZERO = 4'd0;

    // Nibbles 10..15 are not decimal digits; they saturate to 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_counter_scan_if.sv
// Control and display bus of bcd_counter_scan.
//   EN, UP, CLR, LOAD, D_IN, LZB : counter controls (driven by master)
//   COUNT, TC                    : parallel count and terminal-count pulse
//   BCD_OUT, AN, BLANK           : scanned digit, one-cold anode select, blank flag
// master = the controlling logic, slave = the counter.
interface bcd_counter_scan_if
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
);
    logic                      EN;
    logic                      UP;
    logic                      CLR;
    logic                      LOAD;
    logic [BCD_W*N_DIGITS-1:0] D_IN;
    logic                      LZB;
    logic [BCD_W*N_DIGITS-1:0] COUNT;
    logic                      TC;
    logic [BCD_W-1:0]          BCD_OUT;
    logic [N_DIGITS-1:0]       AN;
    logic                      BLANK;

    modport master (
        output EN, UP, CLR, LOAD, D_IN, LZB,
        input  COUNT, TC, BCD_OUT, AN, BLANK
    );

    modport slave (
        input  EN, UP, CLR, LOAD, D_IN, LZB,
        output COUNT, TC, BCD_OUT, AN, BLANK
    );
endinterface

// File: rtl/bcd_digit.sv
// One registered BCD digit of the counter chain.
//   clk, reset   : clock, asynchronous active-high reset
//   clr_i        : synchronous clear (highest priority)
//   load_i       : synchronous load of load_val_i (clamped to 0..9)
//   en_i, up_i   : global count enable and direction
//   cin_i        : carry (up) / borrow (down) from the less significant digit
//   digit_o      : stored digit, always 0..9
//   cout_o       : carry/borrow to the next digit, combinational
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             cin_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             cout_o
);

    logic [BCD_W-1:0] digit_q, digit_d;
    logic             step;

    // A digit moves only when the whole chain below it is wrapping.
    assign step   = en_i & cin_i;
    assign cout_o = step & (up_i ? (digit_q == BCD_MAX) : (digit_q == BCD_ZERO));

    // NOTE: the hold value is assigned first so no path leaves digit_d unassigned (no latch).
    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = BCD_ZERO;
        end else if (load_i) begin
            digit_d = bcd_clamp(load_val_i);
        end else if (step) begin
            if (up_i) digit_d = (digit_q == BCD_MAX)  ? BCD_ZERO : digit_q + 4'd1;
            else      digit_d = (digit_q == BCD_ZERO) ? BCD_MAX  : digit_q - 4'd1;
        end
    end

    // NOTE: non-blocking assignment for all clocked state so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) digit_q <= BCD_ZERO;
        else       digit_q <= digit_d;
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_counter_scan.sv
// Multi-digit BCD up/down counter with a multiplexed display scanner.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of bcd_counter_scan_if
//                inputs  EN, UP, CLR, LOAD, D_IN, LZB
//                outputs COUNT (parallel count), TC (wrap pulse),
//                        BCD_OUT/AN/BLANK (one digit per scan slot, all registered)
// Parameters: N_DIGITS (1..8) must match the interface; SCAN_DIV (>=2) is the
// number of clocks each digit stays selected.
module bcd_counter_scan
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    bcd_counter_scan_if.slave bus
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [BCD_W-1:0]    digit_w [N_DIGITS];
    logic [N_DIGITS:0]   carry_w;

    logic [PRE_W-1:0]    pre_q,   pre_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic                tc_q,    tc_d;
    logic [BCD_W-1:0]    bcd_q,   bcd_d;
    logic [N_DIGITS-1:0] an_q,    an_d;
    logic                blank_q, blank_d;

    // Digit 0 always steps when enabled; higher digits step on the carry chain.
    assign carry_w[0] = 1'b1;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .clr_i      (bus.CLR),
            .load_i     (bus.LOAD),
            .load_val_i (bus.D_IN[i*BCD_W +: BCD_W]),
            .en_i       (bus.EN),
            .up_i       (bus.UP),
            .cin_i      (carry_w[i]),
            .digit_o    (digit_w[i]),
            .cout_o     (carry_w[i+1])
        );
        assign bus.COUNT[i*BCD_W +: BCD_W] = digit_w[i];
    end

    always_comb begin
        // Prescaler free-runs regardless of the counter controls.
        pre_d = pre_q + 1'b1;
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // Carry out of the top digit means every digit wrapped this edge;
        // CLR and LOAD override counting, so they suppress the pulse.
        tc_d = carry_w[N_DIGITS] & ~bus.CLR & ~bus.LOAD;

        // Display outputs are computed from the current index and count so
        // digit, anode and blank change together on the next edge.
        an_d  = ~(N_DIGITS'(1) << idx_q);
        bcd_d = digit_w[idx_q];

        // Blank a leading zero: this digit and all more significant ones are 0.
        blank_d = bus.LZB && (idx_q != '0);
        for (int j = 0; j < N_DIGITS; j++) begin
            if (j >= int'(idx_q) && digit_w[j] != BCD_ZERO) blank_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            idx_q   <= '0;
            tc_q    <= 1'b0;
            bcd_q   <= BCD_ZERO;
            an_q    <= ~N_DIGITS'(1);
            blank_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            tc_q    <= tc_d;
            bcd_q   <= bcd_d;
            an_q    <= an_d;
            blank_q <= blank_d;
        end
    end

    assign bus.TC      = tc_q;
    assign bus.BCD_OUT = bcd_q;
    assign bus.AN      = an_q;
    assign bus.BLANK   = blank_q;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Directed self-checking bench for bcd_counter_scan (N_DIGITS=4, SCAN_DIV=4).
module tb_bcd_counter_scan;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    bcd_counter_scan_if #(.N_DIGITS(4)) bus ();

    bcd_counter_scan #(
        .N_DIGITS (4),
        .SCAN_DIV (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int bcd_to_int(input logic [15:0] v);
        int r = 0;
        int w = 1;
        for (int i = 0; i < 4; i++) begin
            r = r + int'(v[i*4 +: 4]) * w;
            w = w * 10;
        end
        return r;
    endfunction

    function automatic logic all_digits_valid(input logic [15:0] v);
        logic ok = 1'b1;
        for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Expected scan table for COUNT=0x0047 with LZB=1, indexed by scan slot.
    logic [3:0] exp_an_t    [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] exp_bcd_t   [4] = '{4'd7, 4'd4, 4'd0, 4'd0};
    logic       exp_blank_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int model;
        int slot;
        logic en_r, up_r, tc_exp;

        bus.EN   = 1'b0;
        bus.UP   = 1'b1;
        bus.CLR  = 1'b0;
        bus.LOAD = 1'b0;
        bus.D_IN = 16'h0000;
        bus.LZB  = 1'b0;

        // Reset state
        step();
        step();
        check("rst_count", 32'(bus.COUNT), 32'h0000);
        check("rst_tc",    32'(bus.TC), 32'd0);
        check("rst_an",    32'(bus.AN), 32'b1110);
        check("rst_bcd",   32'(bus.BCD_OUT), 32'd0);
        check("rst_blank", 32'(bus.BLANK), 32'd0);
        reset = 1'b0;

        // Count a few steps, then assert reset between edges
        bus.EN = 1'b1;
        bus.UP = 1'b1;
        repeat (5) step();
        check("pre_rst_count", 32'(bus.COUNT), 32'h0005);
        #2 reset = 1'b1;
        #1;
        check("async_rst_count", 32'(bus.COUNT), 32'h0000);
        check("async_rst_an",    32'(bus.AN), 32'b1110);
        check("async_rst_bcd",   32'(bus.BCD_OUT), 32'd0);
        check("async_rst_tc",    32'(bus.TC), 32'd0);
        #1 reset = 1'b0;
        step();
        check("restart_count", 32'(bus.COUNT), 32'h0001);

        // Load 0998 and count through the decade carries
        bus.EN   = 1'b0;
        bus.LOAD = 1'b1;
        bus.D_IN = 16'h0998;
        step();
        check("load_0998", 32'(bus.COUNT), 32'h0998);
        bus.LOAD = 1'b0;
        bus.EN   = 1'b1;
        step();
        check("inc_0999", 32'(bus.COUNT), 32'h0999);
        check("inc_0999_tc", 32'(bus.TC), 32'd0);
        step();
        check("inc_1000", 32'(bus.COUNT), 32'h1000);
        check("inc_1000_tc", 32'(bus.TC), 32'd0);
        step();
        check("inc_1001", 32'(bus.COUNT), 32'h1001);
        check("inc_1001_tc", 32'(bus.TC), 32'd0);

        // Wrap up from 9999, then wrap down from 0000
        bus.EN   = 1'b0;
        bus.LOAD = 1'b1;
        bus.D_IN = 16'h9999;
        step();
        check("load_9999", 32'(bus.COUNT), 32'h9999);
        check("load_tc", 32'(bus.TC), 32'd0);
        bus.LOAD = 1'b0;
        bus.EN   = 1'b1;
        bus.UP   = 1'b1;
        step();
        check("wrap_up_count", 32'(bus.COUNT), 32'h0000);
        check("wrap_up_tc", 32'(bus.TC), 32'd1);
        bus.UP = 1'b0;
        step();
        check("wrap_dn_count", 32'(bus.COUNT), 32'h9999);
        check("wrap_dn_tc", 32'(bus.TC), 32'd1);
        bus.EN = 1'b0;
        step();
        check("hold_count", 32'(bus.COUNT), 32'h9999);
        check("tc_drop", 32'(bus.TC), 32'd0);

        // Load clamping and CLR priority over LOAD
        bus.LOAD = 1'b1;
        bus.D_IN = 16'hA3F5;
        step();
        check("load_clamp", 32'(bus.COUNT), 32'h9395);
        bus.CLR = 1'b1;
        step();
        check("clr_over_load", 32'(bus.COUNT), 32'h0000);
        bus.CLR  = 1'b0;
        bus.LOAD = 1'b0;

        // Scanner: re-align the prescaler with a reset, then load 0047 on edge 1
        reset = 1'b1;
        #1 reset = 1'b0;
        bus.LZB  = 1'b1;
        bus.EN   = 1'b0;
        bus.LOAD = 1'b1;
        bus.D_IN = 16'h0047;
        step();
        check("scan_load", 32'(bus.COUNT), 32'h0047);
        bus.LOAD = 1'b0;
        // After edge k the displayed slot is ((k-1)/4) mod 4; observe edges 2..21
        for (int k = 2; k <= 21; k++) begin
            step();
            slot = ((k - 1) / 4) % 4;
            check($sformatf("scan_an_e%0d", k),    32'(bus.AN), 32'(exp_an_t[slot]));
            check($sformatf("scan_bcd_e%0d", k),   32'(bus.BCD_OUT), 32'(exp_bcd_t[slot]));
            check($sformatf("scan_blank_e%0d", k), 32'(bus.BLANK), 32'(exp_blank_t[slot]));
        end
        bus.LZB = 1'b0;
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("nolzb_blank_%0d", k), 32'(bus.BLANK), 32'd0);
        end

        // Random enable/direction against a decimal reference model
        reset = 1'b1;
        #1 reset = 1'b0;
        model = 0;
        for (int n = 0; n < 20000; n++) begin
            en_r   = 1'($urandom_range(0, 1));
            up_r   = 1'($urandom_range(0, 1));
            bus.EN = en_r;
            bus.UP = up_r;
            tc_exp = en_r && (up_r ? (model == 9999) : (model == 0));
            if (en_r) model = up_r ? (model + 1) % 10000 : (model + 9999) % 10000;
            step();
            check("rand_count", 32'(bcd_to_int(bus.COUNT)), 32'(model));
            check("rand_valid", 32'(all_digits_valid(bus.COUNT)), 32'd1);
            check("rand_tc", 32'(bus.TC), 32'(tc_exp));
            check("rand_an_onecold", 32'($countones(~bus.AN)), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
